cronometro_contador: RTL and testbench

//   Stopwatch time base. Counts elapsed time in tenths of a second and drives the

---
 rtl/cronometro_contador.sv | 126 ++++++++++++
 tb/tb_cronometro_contador.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cronometro_contador.sv
// rtl/cronometro_contador.sv - stopwatch time base: tenths/seconds counter with start/stop, clear, lap and saturation
module cronometro_contador #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       zerar,
  input  logic       parcial,
  output logic [9:0] seg,
  output logic [3:0] dec,
  output logic       rodando,
  output logic       congelado,
  output logic       estouro,
  output logic       tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    ESTOURO  = 2'd2
  } estado_t;

  estado_t       estado, estado_n;
  logic [2:0]    sync1, sync2, prev;
  logic          start_e, zerar_e, parcial_e;
  logic [9:0]    seg_cnt, seg_n, snap_seg, snap_seg_n;
  logic [3:0]    dec_cnt, dec_n, snap_dec, snap_dec_n;
  logic [PW-1:0] presc, presc_n;
  logic          tick_n, cong_n;

  // Button bit order: {parcial, zerar, start_stop}
  assign start_e   = sync2[0] & ~prev[0];
  assign zerar_e   = sync2[1] & ~prev[1];
  assign parcial_e = sync2[2] & ~prev[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      estado    <= PARADO;
      seg_cnt   <= '0;
      dec_cnt   <= '0;
      presc     <= '0;
      snap_seg  <= '0;
      snap_dec  <= '0;
      congelado <= 1'b0;
      tick      <= 1'b0;
    end else begin
      sync1     <= {parcial, zerar, start_stop};
      sync2     <= sync1;
      prev      <= sync2;
      estado    <= estado_n;
      seg_cnt   <= seg_n;
      dec_cnt   <= dec_n;
      presc     <= presc_n;
      snap_seg  <= snap_seg_n;
      snap_dec  <= snap_dec_n;
      congelado <= cong_n;
      tick      <= tick_n;
    end
  end

  always_comb begin
    estado_n   = estado;
    seg_n      = seg_cnt;
    dec_n      = dec_cnt;
    presc_n    = presc;
    tick_n     = 1'b0;
    cong_n     = congelado;
    snap_seg_n = snap_seg;
    snap_dec_n = snap_dec;
    if (zerar_e) begin
      estado_n = PARADO;
      seg_n    = '0;
      dec_n    = '0;
      presc_n  = '0;
      cong_n   = 1'b0;
    end else begin
      if (estado == CONTANDO) begin
        if (presc == PRESC_MAX) begin
          presc_n = '0;
          tick_n  = 1'b1;
          if (seg_cnt == 10'd999 && dec_cnt == 4'd9) begin
            estado_n = ESTOURO;
          end else if (dec_cnt == 4'd9) begin
            dec_n = '0;
            seg_n = seg_cnt + 10'd1;
          end else begin
            dec_n = dec_cnt + 4'd1;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      // A saturating tick in the same cycle as a stop request keeps ESTOURO
      if (start_e) begin
        if (estado == PARADO)
          estado_n = CONTANDO;
        else if (estado == CONTANDO && estado_n == CONTANDO)
          estado_n = PARADO;
      end
      if (parcial_e) begin
        if (!congelado) begin
          snap_seg_n = seg_n;
          snap_dec_n = dec_n;
          cong_n     = 1'b1;
        end else begin
          cong_n = 1'b0;
        end
      end
    end
  end

  assign seg     = congelado ? snap_seg : seg_cnt;
  assign dec     = congelado ? snap_dec : dec_cnt;
  assign rodando = (estado == CONTANDO);
  assign estouro = (estado == ESTOURO);

endmodule

// File: tb/tb_cronometro_contador.sv
// tb/tb_cronometro_contador.sv - randomized scoreboard bench for cronometro_contador against a tenths-count reference model
module tb_cronometro_contador;

  localparam int CLK_HZ  = 40;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_stop, zerar, parcial;
  logic [9:0] seg;
  logic [3:0] dec;
  logic       rodando, congelado, estouro, tick;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected snapshot: {seg, dec, rodando, congelado, estouro, tick}
  logic [17:0] exp_q[$];

  cronometro_contador #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .zerar(zerar), .parcial(parcial),
    .seg(seg), .dec(dec), .rodando(rodando), .congelado(congelado), .estouro(estouro), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed time as one integer of tenths; mode 0=stopped 1=running 2=saturated
  int   m_mode, m_total, m_phase, m_snap;
  bit   m_frozen, m_tick;
  bit   h_ss[3], h_z[3], h_p[3];

  initial forever begin
    int  shown, mode_before;
    bit  ev_ss, ev_z, ev_p;
    @(posedge clk);
    if (!rst_n) begin
      m_mode = 0; m_total = 0; m_phase = 0; m_snap = 0; m_frozen = 0; m_tick = 0;
      for (int i = 0; i < 3; i++) begin h_ss[i] = 0; h_z[i] = 0; h_p[i] = 0; end
    end else begin
      // A pin level sampled at edge n acts at edge n+2
      ev_ss = h_ss[1] && !h_ss[2];
      ev_z  = h_z[1]  && !h_z[2];
      ev_p  = h_p[1]  && !h_p[2];
      h_ss[2] = h_ss[1]; h_ss[1] = h_ss[0]; h_ss[0] = start_stop;
      h_z[2]  = h_z[1];  h_z[1]  = h_z[0];  h_z[0]  = zerar;
      h_p[2]  = h_p[1];  h_p[1]  = h_p[0];  h_p[0]  = parcial;
      m_tick = 0;
      if (ev_z) begin
        m_mode = 0; m_total = 0; m_phase = 0; m_frozen = 0;
      end else begin
        mode_before = m_mode;
        if (m_mode == 1) begin
          m_phase = m_phase + 1;
          if (m_phase == DIV) begin
            m_phase = 0;
            m_tick  = 1;
            if (m_total == 9999) m_mode = 2;
            else m_total = m_total + 1;
          end
        end
        if (ev_ss) begin
          if (mode_before == 0) m_mode = 1;
          else if (m_mode == 1) m_mode = 0;
        end
        if (ev_p) begin
          if (!m_frozen) begin m_snap = m_total; m_frozen = 1; end
          else m_frozen = 0;
        end
      end
    end
    shown = m_frozen ? m_snap : m_total;
    exp_q.push_back({10'(shown / 10), 4'(shown % 10), m_mode == 1, m_frozen, m_mode == 2, m_tick});
  end

  initial forever begin
    logic [17:0] e, g;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {seg, dec, rodando, congelado, estouro, tick};
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got seg=%0d dec=%0d rod=%0b cong=%0b est=%0b tick=%0b, required seg=%0d dec=%0d rod=%0b cong=%0b est=%0b tick=%0b",
                 $time, g[17:8], g[7:4], g[3], g[2], g[1], g[0], e[17:8], e[7:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_stop = 1'b0; zerar = 1'b0; parcial = 1'b0;
    hold(3);
    rst_n = 1'b1;
    hold(100);

    // Randomized button activity
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 7) == 0)  start_stop = ~start_stop;
      if ($urandom_range(0, 11) == 0) parcial    = ~parcial;
      if ($urandom_range(0, 79) == 0) zerar      = ~zerar;
    end

    // Clear, then run all the way to saturation
    start_stop = 1'b0; parcial = 1'b0; zerar = 1'b0;
    hold(4);
    zerar = 1'b1; hold(4); zerar = 1'b0; hold(4);
    start_stop = 1'b1;
    hold(40010);
    check("sat_estouro", estouro, 1);
    check("sat_seg", seg, 999);
    check("sat_dec", dec, 9);
    check("sat_rodando", rodando, 0);
    start_stop = 1'b0; hold(3); start_stop = 1'b1; hold(6);
    check("sat_ignore_ss", estouro, 1);
    parcial = 1'b1; hold(5);
    check("sat_lap_cong", congelado, 1);
    zerar = 1'b1; hold(5);
    check("zerar_seg", seg, 0);
    check("zerar_estouro", estouro, 0);

    // Mid-count asynchronous reset
    zerar = 1'b0; parcial = 1'b0; start_stop = 1'b0;
    hold(4);
    start_stop = 1'b1;
    hold(30);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {seg, dec, rodando, congelado, estouro, tick}, 0);
    hold(2);
    rst_n = 1'b1;
    hold(20);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
